// File: rtl/hazard_ctrl_pkg.sv
// Shared core types for the hazard controller: shadow-pipeline entry and
// the branch-comparator forwarding select encodings.
package core_pkg;

  localparam int HZ_REG_ADDR_W = 5;

  typedef logic [HZ_REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      writereg;
    logic      readmem;
    reg_addr_t dest;
  } hz_entry_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage <-> hazard controller bundle. The decode side (master) drives
// the ID control info and mem_ready; the controller (slave) returns hz_*.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_is_branch;
  logic                  id_writereg;
  logic [REG_ADDR_W-1:0] id_regdest;
  logic                  id_readmem;
  logic                  id_if_selpcsource;
  logic                  mem_ready;

  logic                  hz_if_stall;
  logic                  hz_id_stall;
  logic                  hz_ex_bubble;
  logic                  hz_id_flush;
  logic [1:0]            hz_fwd_a;
  logic [1:0]            hz_fwd_b;
  logic [CNT_W-1:0]      hz_stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
           id_writereg, id_regdest, id_readmem, id_if_selpcsource, mem_ready,
    input  hz_if_stall, hz_id_stall, hz_ex_bubble, hz_id_flush,
           hz_fwd_a, hz_fwd_b, hz_stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
           id_writereg, id_regdest, id_readmem, id_if_selpcsource, mem_ready,
    output hz_if_stall, hz_id_stall, hz_ex_bubble, hz_id_flush,
           hz_fwd_a, hz_fwd_b, hz_stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_match.sv
// Producer/consumer match for one shadow stage against the ID source
// registers. Register $0 is never a producer.
module hz_match
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W
) (
  input  hz_entry_t             entry,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rs,
  input  logic                  uses_rt,
  output logic                  match_rs,
  output logic                  match_rt,
  output logic                  src_hit
);
  logic live;

  always_comb begin
    live     = entry.valid & entry.writereg & (entry.dest != REG_ZERO);
    match_rs = live & (entry.dest == rs);
    match_rt = live & (entry.dest == rt);
    src_hit  = (uses_rs & match_rs) | (uses_rt & match_rt);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB destination info,
// stall/bubble/flush and ID comparator forwarding. Macro HAZARD_FWD_EN enables
// forwarding; undefined, every RAW dependency on EX or MEM stalls.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic          clock,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);
  hz_entry_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_m_rs, ex_m_rt, ex_hit;
  logic mem_m_rs, mem_m_rt, mem_hit;
  logic wb_m_rs, wb_m_rt, wb_hit;
  logic freeze, hazard;

  hz_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_ex (
    .entry(ex_q), .rs(hz.id_rs), .rt(hz.id_rt),
    .uses_rs(hz.id_uses_rs), .uses_rt(hz.id_uses_rt),
    .match_rs(ex_m_rs), .match_rt(ex_m_rt), .src_hit(ex_hit)
  );

  hz_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_mem (
    .entry(mem_q), .rs(hz.id_rs), .rt(hz.id_rt),
    .uses_rs(hz.id_uses_rs), .uses_rt(hz.id_uses_rt),
    .match_rs(mem_m_rs), .match_rt(mem_m_rt), .src_hit(mem_hit)
  );

  hz_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_wb (
    .entry(wb_q), .rs(hz.id_rs), .rt(hz.id_rt),
    .uses_rs(hz.id_uses_rs), .uses_rt(hz.id_uses_rt),
    .match_rs(wb_m_rs), .match_rt(wb_m_rt), .src_hit(wb_hit)
  );

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    freeze = ~hz.mem_ready;
`ifdef HAZARD_FWD_EN
    // WB never stalls: the register file writes in the first half-cycle.
    hazard = hz.id_valid &
             ((ex_q.readmem & ex_hit) |
              (hz.id_is_branch & (ex_hit | (mem_q.readmem & mem_hit))));
    hz.hz_fwd_a = (mem_m_rs & ~mem_q.readmem) ? FWD_MEM :
                  wb_m_rs                     ? FWD_WB  : FWD_REG;
    hz.hz_fwd_b = (mem_m_rt & ~mem_q.readmem) ? FWD_MEM :
                  wb_m_rt                     ? FWD_WB  : FWD_REG;
`else
    hazard      = hz.id_valid & (ex_hit | mem_hit);
    hz.hz_fwd_a = FWD_REG;
    hz.hz_fwd_b = FWD_REG;
`endif
  end

`ifdef HAZARD_FWD_EN
  logic unused_match;
  assign unused_match = ^{ex_m_rs, ex_m_rt, wb_hit};
`else
  logic unused_match;
  assign unused_match = ^{ex_m_rs, ex_m_rt, mem_m_rs, mem_m_rt,
                          wb_m_rs, wb_m_rt, wb_hit};
`endif

  // Priority freeze > hazard > flush.
  always_comb begin
    hz.hz_if_stall     = freeze | hazard;
    hz.hz_id_stall     = freeze | hazard;
    hz.hz_ex_bubble    = ~freeze & hazard;
    hz.hz_id_flush     = ~freeze & ~hazard & hz.id_if_selpcsource & hz.id_valid;
    hz.hz_stall_cycles = cnt_q;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!freeze) begin
      // A stalled ID instruction enters EX as a bubble; flush does not touch
      // the shadow because the squashed instruction never left IF.
      ex_d = '{valid:    hz.id_valid & ~hazard,
               writereg: hz.id_writereg,
               readmem:  hz.id_readmem,
               dest:     hz.id_regdest};
      mem_d = ex_q;
      wb_d  = mem_q;
      if (hazard && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs; reset is asynchronous, active-low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// against a queue-based reference model. Honours HAZARD_FWD_EN if defined.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int AW = 5;
  localparam int CW = 4;   // narrow counter so saturation is reachable quickly
`ifdef HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hzif ();
  hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .hz(hzif)
  );

  typedef struct {bit valid; bit writereg; bit readmem; int dest;} prod_t;
  typedef struct {bit v, urs, urt, br, wr, rm, sel, mr; int rs, rt, rd;} id_t;

  prod_t stages[$];   // [0]=EX, [1]=MEM, [2]=WB
  int    stall_total;
  id_t   cur;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    obs_stalls;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic id_t mk(bit v, int rs, int rt, bit urs, bit urt, bit br,
                             bit wr, int rd, bit rm, bit sel);
    id_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.br = br;
    x.wr = wr; x.rd = rd; x.rm = rm; x.sel = sel; x.mr = 1'b1;
    return x;
  endfunction

  function automatic bit mt(prod_t p, int r);
    return p.valid && p.writereg && (p.dest != 0) && (p.dest == r);
  endfunction

  function automatic bit hit(prod_t p);
    return (cur.urs && mt(p, cur.rs)) || (cur.urt && mt(p, cur.rt));
  endfunction

  function automatic bit model_hazard();
    if (!cur.v) return 1'b0;
    if (FWD_ON)
      return (stages[0].readmem && hit(stages[0])) ||
             (cur.br && (hit(stages[0]) || (stages[1].readmem && hit(stages[1]))));
    return hit(stages[0]) || hit(stages[1]);
  endfunction

  function automatic int model_fwd(int r);
    if (FWD_ON && mt(stages[1], r) && !stages[1].readmem) return 1;
    if (FWD_ON && mt(stages[2], r)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    prod_t z;
    z = '{valid: 1'b0, writereg: 1'b0, readmem: 1'b0, dest: 0};
    stages.delete();
    repeat (3) stages.push_back(z);
    stall_total = 0;
  endtask

  task automatic drive(id_t x);
    cur = x;
    hzif.id_valid          = x.v;
    hzif.id_rs             = AW'(x.rs);
    hzif.id_rt             = AW'(x.rt);
    hzif.id_uses_rs        = x.urs;
    hzif.id_uses_rt        = x.urt;
    hzif.id_is_branch      = x.br;
    hzif.id_writereg       = x.wr;
    hzif.id_regdest        = AW'(x.rd);
    hzif.id_readmem        = x.rm;
    hzif.id_if_selpcsource = x.sel;
    hzif.mem_ready         = x.mr;
  endtask

  task automatic compare();
    bit h, fr;
    h  = model_hazard();
    fr = !cur.mr;
    check("if_stall",     32'(hzif.hz_if_stall),     32'(fr || h));
    check("id_stall",     32'(hzif.hz_id_stall),     32'(fr || h));
    check("ex_bubble",    32'(hzif.hz_ex_bubble),    32'(!fr && h));
    check("id_flush",     32'(hzif.hz_id_flush),     32'(!fr && !h && cur.sel && cur.v));
    check("fwd_a",        32'(hzif.hz_fwd_a),        32'(model_fwd(cur.rs)));
    check("fwd_b",        32'(hzif.hz_fwd_b),        32'(model_fwd(cur.rt)));
    check("stall_cycles", 32'(hzif.hz_stall_cycles), 32'(stall_total));
  endtask

  // One clock: drive, check mid-cycle, then advance the model at the edge.
  task automatic cyc(id_t x, output bit accepted);
    bit h;
    drive(x);
    @(negedge clock);
    compare();
    obs_stalls += int'(hzif.hz_if_stall);
    h = model_hazard();
    accepted = cur.mr && !h;
    @(posedge clock);
    if (reset && cur.mr) begin
      stages.push_front('{valid: cur.v && !h, writereg: cur.wr,
                          readmem: cur.rm, dest: cur.rd});
      void'(stages.pop_back());
      if (h && stall_total < (1 << CW) - 1) stall_total++;
    end
    #1;
  endtask

  // Hold an instruction in ID until the controller lets it go.
  task automatic issue(id_t x);
    bit acc;
    for (int i = 0; i < 8; i++) begin
      cyc(x, acc);
      if (acc) return;
    end
    check("issue_timeout", 32'd1, 32'd0);
  endtask

  id_t nop, lw5, add6, add3, beq34, beq_tk, lw3, beq3_tk, wr0, rd0, add2, sub7;

  initial begin
    bit acc;
    nop     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw5     = mk(1, 1, 0, 1, 0, 0, 1, 5, 1, 0);
    add6    = mk(1, 5, 1, 1, 1, 0, 1, 6, 0, 0);
    add3    = mk(1, 1, 2, 1, 1, 0, 1, 3, 0, 0);
    beq34   = mk(1, 3, 4, 1, 1, 1, 0, 0, 0, 0);
    beq_tk  = mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 1);
    lw3     = mk(1, 1, 0, 1, 0, 0, 1, 3, 1, 0);
    beq3_tk = mk(1, 3, 4, 1, 1, 1, 0, 0, 0, 1);
    wr0     = mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
    rd0     = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add2    = mk(1, 1, 1, 1, 1, 0, 1, 2, 0, 0);
    sub7    = mk(1, 2, 2, 1, 1, 0, 1, 7, 0, 0);

    // Reset state, including the flush path that ID inputs still drive.
    model_reset();
    drive(nop);
    #3;
    compare();
    drive(beq_tk);
    #1;
    check("reset_flush", 32'(hzif.hz_id_flush), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Load-use.
    repeat (3) issue(nop);
    issue(lw5);
    issue(add6);

    // Branch operands forwarded from MEM, then from WB.
    repeat (3) issue(nop);
    issue(add3); issue(nop); issue(beq34);
    repeat (3) issue(nop);
    issue(add3); issue(nop); issue(nop); issue(beq34);

    // Taken branch alone, then colliding with a load-use hazard.
    repeat (3) issue(nop);
    issue(beq_tk);
    issue(lw3);
    issue(beq3_tk);

    // Memory freeze in the middle of a load-use stall.
    repeat (3) issue(nop);
    issue(lw5);
    add6.mr = 1'b0;
    repeat (3) cyc(add6, acc);
    add6.mr = 1'b1;
    issue(add6);

    // Register $0 is never a producer.
    repeat (3) issue(nop);
    issue(wr0);
    issue(rd0);

    // Dependent ALU pair cost.
    repeat (3) issue(nop);
    issue(add2);
    obs_stalls = 0;
    issue(sub7);
    check("alu_pair_stalls", 32'(obs_stalls), FWD_ON ? 32'd0 : 32'd2);

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      issue(lw5);
      issue(add6);
    end
    issue(nop);
    check("cnt_saturated", 32'(hzif.hz_stall_cycles), 32'((1 << CW) - 1));

    // Asynchronous reset in the middle of a stall.
    repeat (3) issue(nop);
    issue(lw5);
    drive(add6);
    @(negedge clock);
    compare();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_if_stall",  32'(hzif.hz_if_stall),     32'd0);
    check("rst_id_stall",  32'(hzif.hz_id_stall),     32'd0);
    check("rst_bubble",    32'(hzif.hz_ex_bubble),    32'd0);
    check("rst_flush",     32'(hzif.hz_id_flush),     32'd0);
    check("rst_fwd",       32'({hzif.hz_fwd_a, hzif.hz_fwd_b}), 32'd0);
    check("rst_cnt",       32'(hzif.hz_stall_cycles), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Random traffic; a stalled instruction is re-presented until accepted.
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      id_t x;
      if (acc) begin
        x = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      end else begin
        x = cur;
      end
      x.mr = ($urandom_range(0, 7) != 0);
      cyc(x, acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
